// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Brief    : Register file with byte-enabled writes, jump-and-link, forwarding
//             and a per-register scoreboard of pending producers.
//  Revision : 1.0
// ============================================================================
module regfile_sb #(
    parameter int WORDS    = 32,
    parameter int BITS     = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int MERGE    = 0,
    parameter int LINK_REG = WORDS - 1
) (
    input  logic                           clk,
    input  logic                           rst_,
    input  logic                           we_,
    input  logic [$clog2(WORDS)-1:0]       waddr,
    input  logic [BITS-1:0]                wdata,
    input  logic [BITS/8-1:0]              byte_en,
    input  logic                           link,
    input  logic [BITS-1:0]                pc_addr,
    input  logic                           sb_set,
    input  logic [$clog2(WORDS)-1:0]       sb_addr,
    input  logic [NRD*$clog2(WORDS)-1:0]   r_addr,
    output logic [NRD*BITS-1:0]            r_data,
    output logic [NRD-1:0]                 r_busy,
    output logic [$clog2(WORDS):0]         pend_cnt
);

    localparam int AW    = $clog2(WORDS);
    localparam int BYTES = BITS / 8;
    localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

    logic [BITS-1:0]  mem [WORDS];
    logic [WORDS-1:0] pend;
    logic [WORDS-1:0] pend_nxt;
    logic [WORDS-1:0] commit;
    logic             link_en;
    logic             wr_en;
    logic             set_en;
    logic             inc;
    logic [1:0]       dec;
    logic [BITS-1:0]  link_val;
    logic [BITS-1:0]  wr_val;
    logic [BITS-1:0]  old_val;
    logic             keep;

    // Gating with rst_ keeps forwarded values and busy overrides at zero during reset.
    assign link_en  = rst_ && link && (LINK_IDX != '0);
    assign wr_en    = rst_ && !we_ && (waddr != '0) && !(link_en && (waddr == LINK_IDX));
    assign set_en   = rst_ && sb_set && (sb_addr != '0);
    assign link_val = pc_addr + BITS'(1);
    assign old_val  = mem[waddr];

    always_comb begin
        wr_val = '0;
        keep   = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            if (MERGE != 0)                  keep = byte_en[i];
            else if (byte_en == BYTES'(1))   keep = (i == 0);
            else if (byte_en == BYTES'(3))   keep = (i < 2);
            else                             keep = 1'b1;
            wr_val[i*8 +: 8] = keep ? wdata[i*8 +: 8]
                             : ((MERGE != 0) ? old_val[i*8 +: 8] : 8'h00);
        end
    end

    always_comb begin
        commit = '0;
        if (wr_en)   commit[waddr]    = 1'b1;
        if (link_en) commit[LINK_IDX] = 1'b1;
    end

    // A same-cycle set beats the clear from a commit to that register.
    always_comb begin
        pend_nxt = pend & ~commit;
        dec      = 2'd0;
        for (int i = 0; i < WORDS; i++) begin
            if (commit[i] && pend[i] && !(set_en && (sb_addr == AW'(i))))
                dec = dec + 2'd1;
        end
        if (set_en) pend_nxt[sb_addr] = 1'b1;
        inc = set_en && !pend[sb_addr];
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_en)   mem[waddr]    <= wr_val;
            if (link_en) mem[LINK_IDX] <= link_val;
            pend     <= pend_nxt;
            pend_cnt <= pend_cnt + {{AW{1'b0}}, inc} - {{(AW-1){1'b0}}, dec};
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [BITS-1:0] rd_val;
            logic            rd_busy;

            assign ra = r_addr[k*AW +: AW];

            always_comb begin
                rd_val  = mem[ra];
                rd_busy = pend[ra];
                if (BYPASS != 0) begin
                    if (link_en && (ra == LINK_IDX))  rd_val = link_val;
                    else if (wr_en && (ra == waddr))  rd_val = wr_val;
                    if (commit[ra] && !(set_en && (sb_addr == ra))) rd_busy = 1'b0;
                end
            end

            assign r_data[k*BITS +: BITS] = rd_val;
            assign r_busy[k]              = rd_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Brief    : Scoreboard bench for regfile_sb; DUT A (MERGE=0, BYPASS=1) and
//             DUT B (MERGE=1, BYPASS=0) share stimulus, each with its own model.
//  Revision : 1.0
// ============================================================================
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        we_ = 1'b1;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byte_en = '0;
    logic        link = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_addr = '0;
    logic [9:0]  r_addr = '0;
    logic [63:0] rd_a, rd_b;
    logic [1:0]  busy_a, busy_b;
    logic [5:0]  cnt_a, cnt_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.WORDS(32), .BITS(32), .NRD(2), .BYPASS(1), .MERGE(0), .LINK_REG(31)) dut_a (
        .clk(clk), .rst_(rst_), .we_(we_), .waddr(waddr), .wdata(wdata), .byte_en(byte_en),
        .link(link), .pc_addr(pc_addr), .sb_set(sb_set), .sb_addr(sb_addr),
        .r_addr(r_addr), .r_data(rd_a), .r_busy(busy_a), .pend_cnt(cnt_a));

    regfile_sb #(.WORDS(32), .BITS(32), .NRD(2), .BYPASS(0), .MERGE(1), .LINK_REG(31)) dut_b (
        .clk(clk), .rst_(rst_), .we_(we_), .waddr(waddr), .wdata(wdata), .byte_en(byte_en),
        .link(link), .pc_addr(pc_addr), .sb_set(sb_set), .sb_addr(sb_addr),
        .r_addr(r_addr), .r_data(rd_b), .r_busy(busy_b), .pend_cnt(cnt_b));

    typedef struct {
        int               id;
        logic [1:0][63:0] rd;
        logic [1:0][1:0]  busy;
        logic [1:0][5:0]  cnt;
    } exp_t;

    exp_t sbq [$];

    // Reference state: index 0 models DUT A, index 1 models DUT B.
    logic [31:0] mreg  [2][32];
    bit          mpend [2][32];

    function automatic logic [31:0] wval(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be, input bit merge);
        logic [31:0] r;
        if (merge) begin
            r = old;
            for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        end else begin
            case (be)
                4'b0001: r = {24'h0, wd[7:0]};
                4'b0011: r = {16'h0, wd[15:0]};
                default: r = wd;
            endcase
        end
        return r;
    endfunction

    task automatic step(input logic rn, input logic wn, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] be, input logic lk,
                        input logic [31:0] pc, input logic ss, input logic [4:0] sa,
                        input logic [4:0] a0, input logic [4:0] a1);
        exp_t        e;
        bit          byp, wgo, hit;
        logic [31:0] nv, lv, v;
        logic [4:0]  a;
        int          pc_cnt;
        @(posedge clk);
        #1;
        rst_ = rn; we_ = wn; waddr = wa; wdata = wd; byte_en = be;
        link = lk; pc_addr = pc; sb_set = ss; sb_addr = sa; r_addr = {a1, a0};
        cyc++;
        e.id = cyc;
        lv = pc + 32'd1;
        for (int m = 0; m < 2; m++) begin
            byp = (m == 0);
            if (!rn) begin
                for (int i = 0; i < 32; i++) begin mreg[m][i] = '0; mpend[m][i] = 0; end
            end
            wgo = rn && !wn && (wa != 0) && !(lk && wa == 5'd31);
            nv  = wval(mreg[m][wa], wd, be, m == 1);
            for (int k = 0; k < 2; k++) begin
                a   = (k == 0) ? a0 : a1;
                hit = rn && ((lk && a == 5'd31) || (wgo && a == wa));
                if (a == 0)                          v = '0;
                else if (byp && rn && lk && a == 31) v = lv;
                else if (byp && wgo && a == wa)      v = nv;
                else                                 v = mreg[m][a];
                e.rd[m][k*32 +: 32] = v;
                e.busy[m][k] = mpend[m][a] && !(byp && hit && !(rn && ss && sa == a));
            end
            pc_cnt = 0;
            for (int i = 0; i < 32; i++) pc_cnt += int'(mpend[m][i]);
            e.cnt[m] = 6'(pc_cnt);
            if (rn) begin
                if (wgo) begin mreg[m][wa] = nv; mpend[m][wa] = 0; end
                if (lk)  begin mreg[m][31] = lv; mpend[m][31] = 0; end
                if (ss && sa != 0) mpend[m][sa] = 1;
            end
        end
        sbq.push_back(e);
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, a0, a1);
    endtask

    task automatic chk(input int id, input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL cyc%0d %s: got %h expected %h", id, nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk(e.id, "A r_data",   rd_a,          e.rd[0]);
            chk(e.id, "A r_busy",   64'(busy_a),   64'(e.busy[0]));
            chk(e.id, "A pend_cnt", 64'(cnt_a),    64'(e.cnt[0]));
            chk(e.id, "B r_data",   rd_b,          e.rd[1]);
            chk(e.id, "B r_busy",   64'(busy_b),   64'(e.busy[1]));
            chk(e.id, "B pend_cnt", 64'(cnt_b),    64'(e.cnt[1]));
        end
    end

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 5'd31;
            1:       return 5'd0;
            5:       return 5'($urandom_range(0, 31));
            default: return 5'($urandom_range(1, 7));
        endcase
    endfunction

    function automatic logic [3:0] pick_be();
        case ($urandom_range(0, 5))
            0: return 4'b0001;
            1: return 4'b0011;
            2: return 4'b0100;
            3: return 4'b0000;
            4: return 4'b1111;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        logic [4:0] wa, sa, ra [2];
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 32; i++) begin mreg[m][i] = '0; mpend[m][i] = 0; end

        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 5, 32'hFFFF_FFFF, 4'hF, 1, 0, 1, 3, 5, 31);
        step(1, 0, 5, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 5, 0);
        idle(5, 0);
        step(1, 0, 5, 32'h1234_5678, 4'b0001, 0, 0, 0, 0, 5, 0);
        idle(5, 0);
        step(1, 0, 5, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 5, 0);
        step(1, 0, 5, 32'h1234_5678, 4'b0100, 0, 0, 0, 0, 5, 0);
        idle(5, 31);
        step(1, 0, 31, 32'h55, 4'hF, 1, 32'h100, 0, 0, 31, 5);
        step(1, 0, 0, 32'hFF, 4'hF, 0, 0, 0, 0, 0, 31);
        idle(0, 31);
        step(1, 0, 2, 32'hA5A5_A5A5, 4'hF, 1, 32'hFFFF_FFFF, 0, 0, 31, 2);
        idle(31, 2);
        step(1, 1, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(7, 0);
        step(1, 0, 7, 32'h77, 4'hF, 0, 0, 1, 7, 7, 0);
        idle(7, 0);
        step(1, 0, 7, 32'h88, 4'hF, 0, 0, 0, 0, 7, 0);
        idle(7, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1, 3, 3, 4);
        step(1, 1, 0, 0, 0, 0, 0, 1, 4, 3, 4);
        step(1, 1, 0, 0, 0, 0, 0, 1, 9, 9, 5);
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 3, 9);
        step(0, 0, 3, 32'h33, 4'hF, 0, 0, 1, 6, 3, 4);
        idle(9, 5);

        for (int n = 0; n < 600; n++) begin
            wa = pick_addr();
            sa = ($urandom_range(0, 2) == 0) ? wa : pick_addr();
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 3))
                    0: ra[k] = wa;
                    1: ra[k] = sa;
                    2: ra[k] = 5'd31;
                    default: ra[k] = 5'($urandom_range(0, 31));
                endcase
            end
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 0), wa, $urandom,
                 pick_be(), ($urandom_range(0, 4) == 0), $urandom,
                 ($urandom_range(0, 2) == 0), sa, ra[0], ra[1]);
        end
        idle(0, 0);

        for (int i = 0; i < 4 && sbq.size() > 0; i++) @(posedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter WORDS, default 32, number of registers (power of 2, >=4).
REQ-002 SHALL provide parameter BITS, default 32, bits per register (multiple of 8); BYTES=BITS/8, AW=$clog2(WORDS).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL provide parameter BYPASS, default 1, 1=write-to-read forwarding enabled.
REQ-005 SHALL provide parameter MERGE, default 0, 0=partial writes zero-fill, 1=partial writes preserve unenabled bytes.
REQ-006 SHALL provide parameter LINK_REG, default WORDS-1, register index written by link.
REQ-007 clk  input  1  system clock, all state on rising edge.
REQ-008 rst_  input  1  reset, asynchronous, active-low.
REQ-009 we_  input  1  write enable, active-low (0=write).
REQ-010 waddr  input  AW  write register index.
REQ-011 wdata  input  BITS  write data.
REQ-012 byte_en  input  BYTES  byte enables, bit i = byte i.
REQ-013 link  input  1  jump-and-link: write pc_addr+1 to LINK_REG.
REQ-014 pc_addr  input  BITS  program counter for link.
REQ-015 sb_set  input  1  mark sb_addr pending (producer issued).
REQ-016 sb_addr  input  AW  register index to mark pending.
REQ-017 r_addr  input  NRD*AW  read indices, port k at [k*AW +: AW].
REQ-018 r_data  output  NRD*BITS  read data, port k at [k*BITS +: BITS].
REQ-019 r_busy  output  NRD  port k source register pending.
REQ-020 pend_cnt  output  AW+1  number of registers currently pending.

Function
REQ-021 Register 0 SHALL read 0, never be written, never be pending; writes/sb_set to index 0 ignored.
REQ-022 Normal write SHALL commit at clock edge when we_=0 and waddr!=0.
REQ-023 MERGE=0: byte_en 0001 -> {0,wdata[7:0]}; 0011 -> {0,wdata[15:0]}; any other value -> full wdata.
REQ-024 MERGE=1: each byte i SHALL take wdata byte i if byte_en[i]=1, else keep old byte; byte_en all-0 SHALL leave the register unchanged yet still count as commit.
REQ-025 link=1 SHALL write pc_addr+1 (modulo 2^BITS) to LINK_REG full width; if normal write targets LINK_REG same cycle, link wins and normal write dropped.
REQ-026 Link and normal write to different registers same cycle SHALL both commit.
REQ-027 Reads SHALL be combinational; BYPASS=0: value as of last edge.
REQ-028 BYPASS=1: port reading a register committing this cycle SHALL return the post-commit value (merged/zero-filled, or pc_addr+1 for link), same cycle.
REQ-029 Pending bit SHALL set at edge with sb_set=1; SHALL clear at edge when that register commits (normal or link).
REQ-030 sb_set and commit to the same register same cycle: set SHALL win (bit=1 after edge).
REQ-031 r_busy[k] = pending bit of r_addr port k; BYPASS=1 SHALL force 0 when that register commits this cycle and sb_set does not target it.
REQ-032 pend_cnt SHALL equal population count of pending bits, updated each edge by at most +1/-2, never wrapping (max WORDS-1).
REQ-033 sb_set on an already-pending register SHALL leave pend_cnt unchanged.

Reset
REQ-034 rst_=0 SHALL immediately clear all registers, all pending bits, pend_cnt=0; r_data reads 0, r_busy=0.
REQ-035 Reset mid-operation SHALL discard same-cycle writes/sb_set; first commit possible on first edge after rst_ rises.

Verification
REQ-036 Reset, then we_=0 waddr=5 wdata=0xDEADBEEF byte_en=1111, read port0 addr5 -> BYPASS=1: 0xDEADBEEF same cycle; BYPASS=0: next cycle.
REQ-037 MERGE=0 reg5=0xDEADBEEF, write wdata=0x12345678 byte_en=0001 -> 0x00000078; MERGE=1 byte_en=0100 -> 0xDE34BEEF.
REQ-038 link=1 pc_addr=0x100, we_=0 waddr=31 wdata=0x55 -> reg31=0x101; write waddr=0 wdata=0xFF -> reg0 reads 0.
REQ-039 sb_set addr 7 -> r_busy=1, pend_cnt=1; commit reg7 with sb_set addr 7 same cycle -> busy stays 1, pend_cnt=1; commit alone -> 0, 0.
REQ-040 Set pending 3,4,9, assert rst_=0 between edges -> pend_cnt=0, all reads 0 immediately.
